// File: rtl/sgd_trainer_if.sv
// Data-point RAM read channel: trainer (master) requests a point, RAM (slave) returns it.
interface sgd_trainer_if #(
  parameter int ADDR_W     = 12,
  parameter int DATA_WIDTH = 192
);
  logic                  rd_req;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  data_valid;

  modport master (output rd_req, output addr, input data, input data_valid);
  modport slave  (input rd_req, input addr, output data, output data_valid);
endinterface

// File: rtl/sgd_trainer.sv
// Fixed-point SGD linear-regression trainer: streams points, updates bias + F weights.
module sgd_trainer #(
  parameter int              LENGTH     = 16,
  parameter int              FRAC       = 8,
  parameter int              F          = 11,
  parameter int              ADDR_W     = 12,
  parameter logic [LENGTH-1:0] W_INIT   = 16'h0100,
  parameter int              DATA_WIDTH = (F+1)*LENGTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              hold,
  input  logic [3:0]        feat,
  input  logic [ADDR_W-1:0] data_points,
  input  logic [7:0]        epoch,
  input  logic [3:0]        learn_rate,
  sgd_trainer_if.master     mem,
  output logic              busy,
  output logic              done,
  output logic              sat_flag,
  output logic [7:0]        epoch_count,
  input  logic [3:0]        w_sel,
  output logic [LENGTH-1:0] w_out
);
  localparam int          SW = LENGTH + 8;  // prediction accumulator width
  localparam int          EW = SW + 1;      // headroom for error/update sums
  localparam int unsigned FU = F;
  localparam logic [LENGTH-1:0] SMAX = {1'b0, {(LENGTH-1){1'b1}}};
  localparam logic [LENGTH-1:0] SMIN = {1'b1, {(LENGTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_PRED, S_ERR, S_UPD, S_NEXT, S_DONE
  } state_t;

  state_t                   r_state;
  logic                     r_rd_req, r_busy, r_done, r_sat;
  logic [ADDR_W-1:0]        r_addr, r_npts;
  logic [7:0]               r_epochs, r_ecnt;
  logic [3:0]               r_feat, r_lr;
  logic signed [LENGTH-1:0] r_w [0:F];
  logic signed [LENGTH-1:0] r_x [1:F];
  logic signed [LENGTH-1:0] r_y, r_g;
  logic signed [SW-1:0]     r_ycap;

  logic signed [SW-1:0]       w_acc;
  logic signed [2*LENGTH-1:0] w_prod, w_gx;
  logic signed [EW-1:0]       w_diff;
  logic [LENGTH:0]            w_esat;
  logic [LENGTH:0]            w_upd [0:F];
  logic                       w_usat;

  // Returns {overflow, value clamped to LENGTH bits}.
  function automatic logic [LENGTH:0] sat_w(input logic signed [EW-1:0] v);
    if ((&v[EW-1:LENGTH-1]) || !(|v[EW-1:LENGTH-1])) return {1'b0, v[LENGTH-1:0]};
    else if (v[EW-1])                                 return {1'b1, SMIN};
    else                                              return {1'b1, SMAX};
  endfunction

  // Prediction: bias plus sum of rescaled products, wrapping in SW bits.
  always_comb begin
    w_acc  = SW'(r_w[0]);
    w_prod = '0;
    for (int unsigned j = 1; j <= FU; j++) begin
      w_prod = r_w[j] * r_x[j];
      w_acc  = w_acc + SW'(w_prod >>> FRAC);
    end
  end

  // Saturated prediction error.
  always_comb begin
    w_diff = EW'(r_y) - EW'(r_ycap);
    w_esat = sat_w(w_diff);
  end

  // Candidate weight updates; overflow only counts for active features.
  always_comb begin
    w_gx     = '0;
    w_upd[0] = sat_w(EW'(r_w[0]) + EW'(r_g));
    w_usat   = w_upd[0][LENGTH];
    for (int unsigned j = 1; j <= FU; j++) begin
      w_gx     = r_g * r_x[j];
      w_upd[j] = sat_w(EW'(r_w[j]) + EW'(w_gx >>> FRAC));
      if (j <= 32'(r_feat)) w_usat = w_usat | w_upd[j][LENGTH];
    end
  end

  // Control FSM, datapath registers and registered status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_rd_req <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sat    <= 1'b0;
      r_addr   <= '0;
      r_npts   <= '0;
      r_epochs <= '0;
      r_ecnt   <= '0;
      r_feat   <= '0;
      r_lr     <= '0;
      r_y      <= '0;
      r_g      <= '0;
      r_ycap   <= '0;
      for (int unsigned j = 0; j <= FU; j++) r_w[j] <= W_INIT;
      for (int unsigned j = 1; j <= FU; j++) r_x[j] <= '0;
    end else if (!hold) begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_feat   <= (feat > 4'(F)) ? 4'(F) : feat;
            r_npts   <= data_points;
            r_epochs <= epoch;
            r_lr     <= learn_rate;
            r_addr   <= '0;
            r_ecnt   <= '0;
            r_sat    <= 1'b0;
            for (int unsigned j = 0; j <= FU; j++) r_w[j] <= W_INIT;
            if (data_points == '0 || epoch == '0) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_rd_req <= 1'b0;
            end else begin
              r_state  <= S_FETCH;
              r_done   <= 1'b0;
              r_busy   <= 1'b1;
              r_rd_req <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (mem.data_valid) begin
            r_y <= mem.data[DATA_WIDTH-1 -: LENGTH];
            for (int unsigned j = 1; j <= FU; j++)
              r_x[j] <= (j <= 32'(r_feat)) ? mem.data[DATA_WIDTH-1-j*LENGTH -: LENGTH] : '0;
            r_rd_req <= 1'b0;
            r_state  <= S_PRED;
          end
        end
        S_PRED: begin
          r_ycap  <= w_acc;
          r_state <= S_ERR;
        end
        S_ERR: begin
          r_g <= $signed(w_esat[LENGTH-1:0]) >>> r_lr;
          if (w_esat[LENGTH]) r_sat <= 1'b1;
          r_state <= S_UPD;
        end
        S_UPD: begin
          r_w[0] <= w_upd[0][LENGTH-1:0];
          for (int unsigned j = 1; j <= FU; j++)
            if (j <= 32'(r_feat)) r_w[j] <= w_upd[j][LENGTH-1:0];
          if (w_usat) r_sat <= 1'b1;
          r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (r_addr == r_npts - ADDR_W'(1)) begin
            r_addr <= '0;
            r_ecnt <= r_ecnt + 8'd1;
            if (r_ecnt + 8'd1 == r_epochs) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state  <= S_FETCH;
              r_rd_req <= 1'b1;
            end
          end else begin
            r_addr   <= r_addr + ADDR_W'(1);
            r_state  <= S_FETCH;
            r_rd_req <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Weight readout port.
  always_comb begin
    if (w_sel > 4'(F)) w_out = '0;
    else               w_out = r_w[w_sel];
  end

  assign mem.rd_req  = r_rd_req & ~hold;
  assign mem.addr    = r_addr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign sat_flag    = r_sat;
  assign epoch_count = r_ecnt;
endmodule

// File: tb/tb_sgd_trainer.sv
// Directed bench for sgd_trainer: single-point vector table plus multi-cycle sequences.
module tb_sgd_trainer;
  logic        CLK = 1'b0;
  logic        RST, start, hold, dv_tie;
  logic [3:0]  feat, learn_rate, w_sel;
  logic [11:0] data_points;
  logic [7:0]  epoch;
  logic        busy, done, sat_flag;
  logic [7:0]  epoch_count;
  logic [15:0] w_out;
  logic [191:0] ram [0:7];
  int          lat = 0;
  int          cnt = 0;
  logic        rd_prev = 1'b0;
  logic [11:0] addr_log [$];
  int          n_pass = 0;
  int          n_tot  = 0;

  sgd_trainer_if #(.ADDR_W(12), .DATA_WIDTH(192)) mem ();

  sgd_trainer #(.LENGTH(16), .FRAC(8), .F(11), .ADDR_W(12), .W_INIT(16'h0100)) dut (
    .CLK(CLK), .RST(RST), .start(start), .hold(hold), .feat(feat),
    .data_points(data_points), .epoch(epoch), .learn_rate(learn_rate),
    .mem(mem), .busy(busy), .done(done), .sat_flag(sat_flag),
    .epoch_count(epoch_count), .w_sel(w_sel), .w_out(w_out)
  );

  always #5 CLK = ~CLK;

  assign mem.data       = ram[mem.addr[2:0]];
  assign mem.data_valid = dv_tie | (mem.rd_req && (cnt >= lat));

  // RAM latency model: counts cycles of an outstanding request.
  always @(posedge CLK) cnt <= mem.rd_req ? cnt + 1 : 0;

  // Logs the address of every rd_req episode.
  always @(posedge CLK) begin
    if (mem.rd_req && !rd_prev) addr_log.push_back(mem.addr);
    rd_prev <= mem.rd_req;
  end

  typedef struct {
    logic [3:0]  f;
    logic [3:0]  lr;
    logic [15:0] x1;
    logic [15:0] y;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    logic        sat;
  } vec_t;

  vec_t vec [6];

  function automatic logic [191:0] pack(input logic [15:0] y, input logic [15:0] x1,
                                        input logic [15:0] x2);
    logic [191:0] p;
    p = '0;
    p[191:176] = y;
    p[175:160] = x1;
    p[159:144] = x2;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic rdw(input logic [3:0] s, input logic [15:0] exp, input string name);
    @(negedge CLK);
    w_sel = s;
    #1;
    chk(name, 32'(w_out), 32'(exp));
  endtask

  task automatic do_start(input logic [3:0] f, input logic [11:0] n, input logic [7:0] e,
                          input logic [3:0] lr);
    @(negedge CLK);
    feat = f; data_points = n; epoch = e; learn_rate = lr; start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int edges);
    edges = 0;
    while (!done && edges < limit) begin
      @(posedge CLK);
      #1;
      edges++;
    end
  endtask

  initial begin
    int edges;
    bit found;
    RST = 1'b1; start = 1'b0; hold = 1'b0; dv_tie = 1'b0;
    feat = '0; learn_rate = '0; w_sel = '0; data_points = '0; epoch = '0;
    for (int i = 0; i < 8; i++) ram[i] = '0;

    vec[0] = '{f: 4'd1,  lr: 4'd0, x1: 16'h0200, y: 16'h0500, w0: 16'h0300, w1: 16'h0500, w2: 16'h0100, sat: 1'b0};
    vec[1] = '{f: 4'd1,  lr: 4'd1, x1: 16'h0200, y: 16'h0500, w0: 16'h0200, w1: 16'h0300, w2: 16'h0100, sat: 1'b0};
    vec[2] = '{f: 4'd1,  lr: 4'd0, x1: 16'h8000, y: 16'h7F00, w0: 16'h7FFF, w1: 16'h8000, w2: 16'h0100, sat: 1'b1};
    vec[3] = '{f: 4'd0,  lr: 4'd0, x1: 16'h0200, y: 16'h0500, w0: 16'h0500, w1: 16'h0100, w2: 16'h0100, sat: 1'b0};
    vec[4] = '{f: 4'd1,  lr: 4'd2, x1: 16'h0100, y: 16'h0100, w0: 16'h00C0, w1: 16'h00C0, w2: 16'h0100, sat: 1'b0};
    vec[5] = '{f: 4'd15, lr: 4'd0, x1: 16'h0200, y: 16'h0500, w0: 16'h0000, w1: 16'hFF00, w2: 16'hFE00, sat: 1'b0};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_req", 32'(mem.rd_req), 0);
    chk("rst_addr", 32'(mem.addr), 0);
    chk("rst_sat", 32'(sat_flag), 0);
    chk("rst_ecnt", 32'(epoch_count), 0);
    rdw(4'd0, 16'h0100, "rst_w0");
    rdw(4'd12, 16'h0000, "rst_wsel_oob");
    rdw(4'd15, 16'h0000, "rst_wsel_15");

    // Single-point, single-epoch vectors with data_valid tied high.
    dv_tie = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ram[0] = pack(vec[i].y, vec[i].x1, 16'h0300);
      do_start(vec[i].f, 12'd1, 8'd1, vec[i].lr);
      wait_done(50, edges);
      chk($sformatf("vec%0d_done_edge", i), 32'(edges), 32'd5);
      chk($sformatf("vec%0d_sat", i), 32'(sat_flag), 32'(vec[i].sat));
      chk($sformatf("vec%0d_ecnt", i), 32'(epoch_count), 32'd1);
      rdw(4'd0, vec[i].w0, $sformatf("vec%0d_w0", i));
      rdw(4'd1, vec[i].w1, $sformatf("vec%0d_w1", i));
      rdw(4'd2, vec[i].w2, $sformatf("vec%0d_w2", i));
    end

    // N=4, E=3, two-cycle data latency, with a start pulse while busy.
    dv_tie = 1'b0;
    lat = 2;
    for (int i = 0; i < 4; i++) ram[i] = pack(16'h0100, 16'h0080, 16'h0040);
    addr_log.delete();
    do_start(4'd2, 12'd4, 8'd3, 4'd3);
    edges = 0;
    while (!done && edges < 300) begin
      @(negedge CLK);
      start = (edges == 20);
      if (edges == 20) begin
        data_points = 12'd1;
        chk("seqA_busy_mid", 32'(busy), 1);
      end
      @(posedge CLK);
      #1;
      edges++;
    end
    start = 1'b0;
    chk("seqA_done_edge", 32'(edges), 32'd84);
    chk("seqA_done", 32'(done), 1);
    chk("seqA_ecnt", 32'(epoch_count), 3);
    chk("seqA_episodes", 32'(addr_log.size()), 12);
    for (int i = 0; i < 12; i++)
      if (i < addr_log.size()) chk($sformatf("seqA_addr%0d", i), 32'(addr_log[i]), 32'(i % 4));

    // Hold mid-FETCH of the second point, then reset while in UPD.
    lat = 3;
    ram[0] = pack(16'h0500, 16'h0200, 16'h0300);
    ram[1] = pack(16'h0500, 16'h0200, 16'h0300);
    do_start(4'd1, 12'd2, 8'd1, 4'd0);
    w_sel = 4'd0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge CLK);
      if (mem.rd_req && mem.addr == 12'd1) found = 1'b1;
    end
    chk("seqB_reach_p1", 32'(found), 1);
    hold = 1'b1;
    dv_tie = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      chk($sformatf("seqB_hold%0d_rdreq", k), 32'(mem.rd_req), 0);
      chk($sformatf("seqB_hold%0d_addr", k), 32'(mem.addr), 1);
      chk($sformatf("seqB_hold%0d_busy", k), 32'(busy), 1);
      chk($sformatf("seqB_hold%0d_w0", k), 32'(w_out), 32'h0300);
    end
    hold = 1'b0;
    #1;
    chk("seqB_release_rdreq", 32'(mem.rd_req), 1);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("seqB_pre_upd_w0", 32'(w_out), 32'h0300);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    dv_tie = 1'b0;
    #1;
    chk("seqB_rst_done", 32'(done), 0);
    chk("seqB_rst_busy", 32'(busy), 0);
    chk("seqB_rst_rdreq", 32'(mem.rd_req), 0);
    chk("seqB_rst_addr", 32'(mem.addr), 0);
    chk("seqB_rst_ecnt", 32'(epoch_count), 0);
    for (int s = 0; s < 3; s++) rdw(4'(s), 16'h0100, $sformatf("seqB_rst_w%0d", s));

    // Zero points or zero epochs go straight to DONE without a read.
    addr_log.delete();
    do_start(4'd1, 12'd0, 8'd1, 4'd0);
    chk("seqC_np0_done", 32'(done), 1);
    chk("seqC_np0_busy", 32'(busy), 0);
    do_start(4'd1, 12'd3, 8'd0, 4'd0);
    chk("seqC_ep0_done", 32'(done), 1);
    repeat (3) @(posedge CLK);
    chk("seqC_no_rdreq", 32'(addr_log.size()), 0);
    chk("seqC_ecnt", 32'(epoch_count), 0);
    rdw(4'd0, 16'h0100, "seqC_w0");
    rdw(4'd1, 16'h0100, "seqC_w1");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
